// File: rtl/ps2_pkg.sv
`default_nettype none
// ps2_pkg: FSM state encoding, error codes and protocol byte values shared by the PS/2 host blocks.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_LINE_ACK  = 3'd4,
      ST_WAIT_RESP = 3'd5,
      ST_DONE      = 3'd6,
      ST_ERR       = 3'd7
   } ps2_state_e;

   localparam logic [1:0] ERR_TIMEOUT    = 2'd0;
   localparam logic [1:0] ERR_RESEND     = 2'd1;
   localparam logic [1:0] ERR_NO_ACK     = 2'd2;
   localparam logic [1:0] ERR_UNEXPECTED = 2'd3;

   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_SET_LEDS = 8'hED;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_cmd_if.sv
`default_nettype none
// ps2_host_cmd_if: command handshake, receiver strobe, open-drain line controls and status strobes.
interface ps2_host_cmd_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_byte;
   logic       has_arg;
   logic [7:0] arg_byte;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       ps2clk_in;
   logic       ps2data_in;
   logic       ps2clk_low;
   logic       ps2data_low;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   modport slave (
      input  cmd_valid, cmd_byte, has_arg, arg_byte, rx_valid, rx_byte, ps2clk_in, ps2data_in,
      output cmd_ready, ps2clk_low, ps2data_low, done, err, err_code
   );

   modport master (
      output cmd_valid, cmd_byte, has_arg, arg_byte, rx_valid, rx_byte, ps2clk_in, ps2data_in,
      input  cmd_ready, ps2clk_low, ps2data_low, done, err, err_code
   );
endinterface
`default_nettype wire

// File: rtl/ps2_edge_det.sv
`default_nettype none
// ps2_edge_det: samples the raw PS/2 clock into an 8-deep history and flags a debounced falling edge.
module ps2_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic line_i,
   output logic fall_o
);

   logic [7:0] hist_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= 8'hFF;
      end else begin
         hist_q <= {hist_q[6:0], line_i};
      end
   end

   // Four settled highs followed by four settled lows; fires for exactly one cycle per edge.
   assign fall_o = (hist_q[7:4] == 4'hF) && (hist_q[3:0] == 4'h0);

endmodule
`default_nettype wire

// File: rtl/ps2_host_cmd.sv
`default_nettype none
// ps2_host_cmd: PS/2 host-to-device command sender with optional argument byte and ACK handling.
// Define PS2_RESEND_EN to re-send a byte on 8'hFE up to MAX_RETRY times.
module ps2_host_cmd
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 3
) (
   input  logic          clk,
   input  logic          reset,
   ps2_host_cmd_if.slave bus
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_state_e       state_q, state_d;
   logic [7:0]       cur_q, cur_d;
   logic [7:0]       arg_q, arg_d;
   logic             has_arg_q, has_arg_d;
   logic             is_arg_q, is_arg_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [1:0]       data_sync_q;
   logic             clk_fall;
   logic             timeout;
   logic             frame_bit;

`ifdef PS2_RESEND_EN
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   logic [RTY_W-1:0] retry_q, retry_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retry_q <= '0;
      end else begin
         retry_q <= retry_d;
      end
   end
`else
   logic unused_max_retry;
   assign unused_max_retry = (MAX_RETRY > 0);
`endif

   ps2_edge_det u_clk_edge (
      .clk    (clk),
      .reset  (reset),
      .line_i (bus.ps2clk_in),
      .fall_o (clk_fall)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         arg_q       <= '0;
         has_arg_q   <= 1'b0;
         is_arg_q    <= 1'b0;
         bit_idx_q   <= '0;
         inh_cnt_q   <= '0;
         to_cnt_q    <= '0;
         err_code_q  <= ERR_TIMEOUT;
         data_sync_q <= 2'b11;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         arg_q       <= arg_d;
         has_arg_q   <= has_arg_d;
         is_arg_q    <= is_arg_d;
         bit_idx_q   <= bit_idx_d;
         inh_cnt_q   <= inh_cnt_d;
         to_cnt_q    <= to_cnt_d;
         err_code_q  <= err_code_d;
         data_sync_q <= {data_sync_q[0], bus.ps2data_in};
      end
   end

   assign timeout   = (to_cnt_q == TO_LAST);
   assign frame_bit = (bit_idx_q < 4'd8) ? cur_q[bit_idx_q[2:0]] : odd_parity(cur_q);

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      arg_d      = arg_q;
      has_arg_d  = has_arg_q;
      is_arg_d   = is_arg_q;
      bit_idx_d  = bit_idx_q;
      inh_cnt_d  = inh_cnt_q;
      to_cnt_d   = to_cnt_q + 1'b1;
      err_code_d = err_code_q;
`ifdef PS2_RESEND_EN
      retry_d    = retry_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               cur_d     = bus.cmd_byte;
               arg_d     = bus.arg_byte;
               has_arg_d = bus.has_arg;
               is_arg_d  = 1'b0;
               state_d   = ST_INHIBIT;
`ifdef PS2_RESEND_EN
               retry_d   = '0;
`endif
            end
         end
         ST_INHIBIT: begin
            inh_cnt_d = inh_cnt_q + 1'b1;
            if (inh_cnt_q == INH_LAST) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (clk_fall) begin
               bit_idx_d = '0;
               state_d   = ST_SEND;
            end else if (timeout) begin
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_ERR;
            end
         end
         ST_SEND: begin
            // Index 8 is parity; the edge after it releases the line as the stop bit.
            if (clk_fall) begin
               if (bit_idx_q == 4'd8) begin
                  state_d = ST_LINE_ACK;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end else if (timeout) begin
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_ERR;
            end
         end
         ST_LINE_ACK: begin
            if (clk_fall) begin
               if (!data_sync_q[1]) begin
                  state_d = ST_WAIT_RESP;
               end else begin
                  err_code_d = ERR_NO_ACK;
                  state_d    = ST_ERR;
               end
            end else if (timeout) begin
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_ERR;
            end
         end
         ST_WAIT_RESP: begin
            if (bus.rx_valid) begin
               if (bus.rx_byte == PS2_ACK) begin
                  if (has_arg_q && !is_arg_q) begin
                     cur_d    = arg_q;
                     is_arg_d = 1'b1;
                     state_d  = ST_INHIBIT;
`ifdef PS2_RESEND_EN
                     retry_d  = '0;
`endif
                  end else begin
                     state_d = ST_DONE;
                  end
               end else if (bus.rx_byte == PS2_RESEND) begin
`ifdef PS2_RESEND_EN
                  if (retry_q == RTY_W'(MAX_RETRY)) begin
                     err_code_d = ERR_RESEND;
                     state_d    = ST_ERR;
                  end else begin
                     retry_d = retry_q + 1'b1;
                     state_d = ST_INHIBIT;
                  end
`else
                  err_code_d = ERR_RESEND;
                  state_d    = ST_ERR;
`endif
               end else begin
                  err_code_d = ERR_UNEXPECTED;
                  state_d    = ST_ERR;
               end
            end else if (timeout) begin
               err_code_d = ERR_TIMEOUT;
               state_d    = ST_ERR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_d != state_q) || clk_fall) begin
         to_cnt_d = '0;
      end
      if (state_d != state_q) begin
         inh_cnt_d = '0;
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.ps2clk_low  = (state_q == ST_INHIBIT);
   assign bus.ps2data_low = (state_q == ST_REQ) || ((state_q == ST_SEND) && !frame_bit);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.err         = (state_q == ST_ERR);
   assign bus.err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_cmd.sv
`default_nettype none
// tb_ps2_host_cmd: randomized commands against a PS/2 device model; frames and outcomes are scoreboarded.
module tb_ps2_host_cmd;

   localparam int INH  = 20;
   localparam int TO   = 400;
   localparam int MAXR = 3;
   localparam int HALF = 10;
`ifdef PS2_RESEND_EN
   localparam bit RESEND_EN = 1'b1;
`else
   localparam bit RESEND_EN = 1'b0;
`endif

   typedef struct {
      bit noclk;
      bit abort;
      bit line_ack;
      int resp;
   } act_t;

   typedef struct {
      bit         is_done;
      logic [1:0] code;
   } res_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   bit   abort_point = 1'b0;
   bit   idle_rx_go = 1'b0;
   bit   stop_run = 1'b0;
   int   checks = 0;
   int   failures = 0;

   act_t       act_q[$];
   logic [7:0] frame_q[$];
   res_t       res_q[$];

   ps2_host_cmd_if bus ();

   assign bus.ps2clk_in  = dev_clk & ~bus.ps2clk_low;
   assign bus.ps2data_in = dev_data & ~bus.ps2data_low;

   ps2_host_cmd #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .MAX_RETRY      (MAXR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Device behaviour per frame; mode 0 is random, the others are directed scenarios.
   function automatic act_t pick_act(input int mode, input int idx);
      act_t x;
      int   r;
      x.noclk = 1'b0; x.abort = 1'b0; x.line_ack = 1'b1; x.resp = 32'hFA;
      case (mode)
         2: x.resp = (idx < 3) ? 32'hFE : 32'hFA;
         3: x.resp = 32'hFE;
         4: x.line_ack = 1'b0;
         5: x.noclk = 1'b1;
         6: x.resp = 32'hAA;
         7: x.abort = 1'b1;
         0: begin
            r = $urandom_range(0, 99);
            if (r < 4) x.noclk = 1'b1;
            else if (r < 10) x.line_ack = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 5) x.resp = -1;
            else if (r < 35) x.resp = 32'hFE;
            else if (r < 42) x.resp = (r < 38) ? 32'hAA : 32'h00;
         end
         default: ;
      endcase
      return x;
   endfunction

   // Reference model: walks the protocol rules frame by frame and queues what must be seen.
   task automatic plan(input logic [7:0] c, input bit ha, input logic [7:0] a, input int mode);
      logic [7:0] cur;
      bit         is_arg, fin, has_res;
      int         retries, idx;
      act_t       x;
      res_t       r;
      cur = c; is_arg = 0; fin = 0; has_res = 1; retries = 0; idx = 0;
      r.is_done = 1'b0; r.code = 2'd0;
      while (!fin) begin
         x = pick_act(mode, idx);
         idx++;
         act_q.push_back(x);
         if (x.abort) begin
            fin = 1; has_res = 0;
         end else if (x.noclk) begin
            r.code = 2'd0; fin = 1;
         end else begin
            frame_q.push_back(cur);
            if (!x.line_ack) begin
               r.code = 2'd2; fin = 1;
            end else if (x.resp < 0) begin
               r.code = 2'd0; fin = 1;
            end else if (x.resp == 32'hFA) begin
               if (ha && !is_arg) begin
                  cur = a; is_arg = 1; retries = 0;
               end else begin
                  r.is_done = 1'b1; fin = 1;
               end
            end else if (x.resp == 32'hFE) begin
               if (RESEND_EN && retries < MAXR) retries++;
               else begin r.code = 2'd1; fin = 1; end
            end else begin
               r.code = 2'd3; fin = 1;
            end
         end
      end
      if (has_res) res_q.push_back(r);
   endtask

   // PS/2 device: answers each request-to-send by clocking a frame in and replying via rx_valid.
   initial begin : device
      act_t       x;
      logic [9:0] bits;
      logic [7:0] eb;
      bit         idle_rx_sent;
      bit         released;
      idle_rx_sent = 0;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      forever begin
         @(negedge clk);
         if (idle_rx_go && !idle_rx_sent) begin
            idle_rx_sent = 1;
            bus.rx_byte = 8'hFA; bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_byte = 8'hAA;
            @(negedge clk);
            bus.rx_valid = 1'b0;
         end else if (reset && bus.ps2clk_in && !bus.ps2data_in) begin
            if (act_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unplanned_frame actual=request required=none");
               x.noclk = 1'b1; x.abort = 1'b0; x.line_ack = 1'b0; x.resp = -1;
            end else begin
               x = act_q.pop_front();
            end
            if (x.noclk) begin
               released = 0;
               for (int t = 0; t < 4 * TO && !released; t++) begin
                  @(negedge clk);
                  released = bus.ps2data_in;
               end
               chk("release_after_timeout", {31'd0, released}, 32'd1);
            end else begin
               repeat (6) @(negedge clk);
               for (int k = 1; k <= 11; k++) begin
                  if (k == 11) dev_data = x.line_ack ? 1'b0 : 1'b1;
                  dev_clk = 1'b0;
                  repeat (HALF) @(negedge clk);
                  if (x.abort && k == 5) begin
                     abort_point = 1'b1;
                     wait (reset == 1'b0);
                     wait (reset == 1'b1);
                     break;
                  end
                  if (k <= 10) bits[k-1] = bus.ps2data_in;
                  dev_clk = 1'b1;
                  repeat (HALF) @(negedge clk);
               end
               dev_clk = 1'b1;
               dev_data = 1'b1;
               abort_point = 1'b0;
               if (!x.abort) begin
                  if (frame_q.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL frame_unexpected actual=%0h required=none", bits[7:0]);
                  end else begin
                     eb = frame_q.pop_front();
                     chk("frame_data", {24'd0, bits[7:0]}, {24'd0, eb});
                     chk("frame_parity", {31'd0, bits[8]}, {31'd0, ($countones(eb) % 2 == 0)});
                     chk("frame_stop", {31'd0, bits[9]}, 32'd1);
                  end
                  if (x.line_ack && x.resp >= 0) begin
                     repeat ($urandom_range(5, 30)) @(negedge clk);
                     bus.rx_byte  = x.resp[7:0];
                     bus.rx_valid = 1'b1;
                     @(negedge clk);
                     bus.rx_valid = 1'b0;
                     bus.rx_byte  = 8'($urandom);
                  end
               end
            end
         end
      end
   end

   // Monitor: every done/err strobe is matched against the next expected outcome.
   initial begin : monitor
      res_t r;
      forever begin
         @(negedge clk);
         if (bus.done || bus.err) begin
            if (res_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_strobe actual=done%0b_err%0b required=none", bus.done, bus.err);
            end else begin
               r = res_q.pop_front();
               chk("outcome_done", {31'd0, bus.done}, {31'd0, r.is_done});
               chk("outcome_err", {31'd0, bus.err}, {31'd0, !r.is_done});
               if (!r.is_done) chk("err_code", {30'd0, bus.err_code}, {30'd0, r.code});
               chk("lines_released", {30'd0, bus.ps2clk_low, bus.ps2data_low}, 32'd0);
            end
         end
      end
   end

   task automatic issue(input logic [7:0] c, input bit ha, input logic [7:0] a);
      bit ok;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = bus.cmd_ready;
      end
      chk("ready_before_cmd", {31'd0, ok}, 32'd1);
      bus.cmd_byte = c; bus.has_arg = ha; bus.arg_byte = a; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      // A second request while busy must not disturb the frame in flight.
      bus.cmd_byte = ~c; bus.has_arg = 1'b0; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic [7:0] c, input bit ha, input logic [7:0] a, input int mode);
      bit fin;
      if (stop_run) return;
      plan(c, ha, a, mode);
      issue(c, ha, a);
      fin = 0;
      for (int t = 0; t < 30000 && !fin; t++) begin
         @(negedge clk);
         fin = (res_q.size() == 0) && (act_q.size() == 0);
      end
      if (!fin) begin
         checks++; failures++;
         $display("FAIL cmd_complete actual=pending required=finished cmd=%0h", c);
         stop_run = 1;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : stim
      bit hit;
      bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00; bus.has_arg = 1'b0; bus.arg_byte = 8'h00;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_lines", {30'd0, bus.ps2clk_low, bus.ps2data_low}, 32'd0);
      chk("rst_strobes", {30'd0, bus.done, bus.err}, 32'd0);
      chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);

      idle_rx_go = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_rx_ignored", {31'd0, bus.cmd_ready}, 32'd1);

      run_cmd(8'hED, 1'b1, 8'h02, 1);
      run_cmd(8'hF4, 1'b0, 8'h00, 4);
      run_cmd(8'hF4, 1'b0, 8'h00, 2);
      run_cmd(8'hF3, 1'b1, 8'h20, 2);
      run_cmd(8'hF4, 1'b0, 8'h00, 3);
      run_cmd(8'hF2, 1'b0, 8'h00, 5);
      run_cmd(8'hEE, 1'b0, 8'h00, 6);
      for (int n = 0; n < 24; n++) begin
         run_cmd(8'($urandom), 1'($urandom), 8'($urandom), 0);
      end

      // Reset while the host is driving data bit 4 of 8'hE5 (a 0, so data pulled low).
      if (!stop_run) begin
         plan(8'hE5, 1'b0, 8'h00, 7);
         issue(8'hE5, 1'b0, 8'h00);
         hit = 0;
         for (int t = 0; t < 3000 && !hit; t++) begin
            @(negedge clk);
            hit = abort_point;
         end
         chk("abort_reached", {31'd0, hit}, 32'd1);
         chk("send_bit4_low", {31'd0, bus.ps2data_low}, 32'd1);
         reset = 1'b0;
         #1;
         chk("abort_lines", {30'd0, bus.ps2clk_low, bus.ps2data_low}, 32'd0);
         chk("abort_strobes", {30'd0, bus.done, bus.err}, 32'd0);
         repeat (3) @(negedge clk);
         reset = 1'b1;
         @(posedge clk); #1;
         chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
         repeat (60) @(negedge clk);
         chk("abort_idle", {31'd0, bus.cmd_ready}, 32'd1);
      end

      chk("frames_consumed", frame_q.size(), 32'd0);
      chk("outcomes_consumed", res_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
